i2c_target_byte_rx: RTL

//  I2C target (slave) write-only byte receiver; upstream feeder of the I2C-to-SPI bridge's SPI master stage.

---
 rtl/i2c_target_byte_rx.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target_byte_rx.sv
// ---------------------------------------------------------------------------
// i2c_target_byte_rx
//   Write-only I2C target byte receiver. It oversamples SDA/SCL on the system
//   clock, detects START/STOP, matches a 7-bit write address, ACKs accepted
//   bytes and posts each data byte to a downstream consumer through a
//   valid/ready holding register. No clock stretching: a byte that arrives
//   while the holding register is still full is NACKed and dropped.
//
//   Optional build macro: I2C_GLITCH_FILTER_EN
//     defined   -> 3-sample majority filter after each synchronizer
//                  (1-clk pulses rejected, +2 clk latency)
//     undefined -> synchronizer output feeds edge detection directly
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   synchronous active-low reset
//   sda_i     in   SDA pin level (asynchronous)
//   scl_i     in   SCL pin level (asynchronous)
//   sda_oe    out  1 = pull SDA low (ACK)
//   rx_data   out  received data byte
//   rx_valid  out  rx_data holds an unconsumed byte
//   rx_ready  in   consumer accepts (transfer on rx_valid & rx_ready)
//   rx_first  out  rx_data is the first byte after an address match
//   busy      out  addressed and inside a write transaction
//   overrun   out  one-cycle pulse: byte dropped, holding register full
// ---------------------------------------------------------------------------
module i2c_target_byte_rx #(
    parameter logic [6:0] ADDR        = 7'h2A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sda_i,
    input  logic       scl_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_first,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_DATA     = 3'd3,
        S_DATA_ACK = 3'd4,
        S_IGNORE   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic                   w_sda;
    logic                   w_scl;
    logic                   r_sda_d;
    logic                   r_scl_d;

    logic                   w_start;
    logic                   w_stop;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_last_bit;
    logic [7:0]             w_byte;
    logic                   w_addr_match;
    logic                   w_hold_free;

    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_shift;
    logic                   r_ack;
    logic                   r_ack_phase;
    logic [7:0]             r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rx_first;
    logic                   r_first_pending;
    logic                   r_overrun;

    logic                   w_sda_oe;
    logic                   w_busy;

    // Synchronizers reset to the idle bus level so reset release never
    // fabricates an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sda_sync <= '1;
            r_scl_sync <= '1;
        end else begin
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [2:0] r_sda_flt;
    logic [2:0] r_scl_flt;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sda_flt <= 3'b111;
            r_scl_flt <= 3'b111;
        end else begin
            r_sda_flt <= {r_sda_flt[1:0], r_sda_sync[SYNC_STAGES-1]};
            r_scl_flt <= {r_scl_flt[1:0], r_scl_sync[SYNC_STAGES-1]};
        end
    end

    assign w_sda = maj3(r_sda_flt);
    assign w_scl = maj3(r_scl_flt);
`else
    assign w_sda = r_sda_sync[SYNC_STAGES-1];
    assign w_scl = r_scl_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sda_d <= 1'b1;
            r_scl_d <= 1'b1;
        end else begin
            r_sda_d <= w_sda;
            r_scl_d <= w_scl;
        end
    end

    // SCL must be high on both samples so an SDA change right at an SCL
    // edge is never taken for START/STOP.
    assign w_start    = r_sda_d & ~w_sda & w_scl & r_scl_d;
    assign w_stop     = ~r_sda_d & w_sda & w_scl & r_scl_d;
    assign w_scl_rise = ~r_scl_d & w_scl;
    assign w_scl_fall = r_scl_d & ~w_scl;

    // The 8th bit is taken live from the line so the byte is acted on in
    // the same cycle its last SCL rise is seen.
    assign w_last_bit   = w_scl_rise && (r_bit_cnt == 3'd7);
    assign w_byte       = {r_shift, w_sda};
    assign w_addr_match = (w_byte == {ADDR, 1'b0});
    assign w_hold_free  = ~r_rx_valid | rx_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_last_bit) w_state_nxt = w_addr_match ? S_ADDR_ACK : S_IGNORE;
                end
                S_DATA: begin
                    if (w_last_bit) w_state_nxt = S_DATA_ACK;
                end
                S_ADDR_ACK, S_DATA_ACK: begin
                    if (w_scl_fall && r_ack_phase) w_state_nxt = S_DATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // The ACK window opens at the first SCL fall after the byte and closes
    // at the next fall (r_ack_phase marks the window).
    always_comb begin
        w_sda_oe = 1'b0;
        w_busy   = 1'b0;
        case (r_state)
            S_ADDR_ACK, S_DATA_ACK: begin
                w_busy   = 1'b1;
                w_sda_oe = r_ack & r_ack_phase;
            end
            S_DATA:  w_busy = 1'b1;
            default: begin
                w_busy   = 1'b0;
                w_sda_oe = 1'b0;
            end
        endcase
    end

    // Shift/count, ACK decision and holding register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bit_cnt       <= 3'd0;
            r_shift         <= 7'd0;
            r_ack           <= 1'b0;
            r_ack_phase     <= 1'b0;
            r_rx_data       <= 8'd0;
            r_rx_valid      <= 1'b0;
            r_rx_first      <= 1'b0;
            r_first_pending <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;

            if (w_start || w_stop) begin
                r_bit_cnt   <= 3'd0;
                r_ack       <= 1'b0;
                r_ack_phase <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[5:0], w_sda};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                        if (w_last_bit) begin
                            r_ack_phase <= 1'b0;
                            if (r_state == S_ADDR) begin
                                r_ack <= w_addr_match;
                                if (w_addr_match) r_first_pending <= 1'b1;
                            end else if (w_hold_free) begin
                                r_rx_data       <= w_byte;
                                r_rx_valid      <= 1'b1;
                                r_rx_first      <= r_first_pending;
                                r_first_pending <= 1'b0;
                                r_ack           <= 1'b1;
                            end else begin
                                r_ack     <= 1'b0;
                                r_overrun <= 1'b1;
                            end
                        end
                    end
                    S_ADDR_ACK, S_DATA_ACK: begin
                        if (w_scl_fall) r_ack_phase <= ~r_ack_phase;
                    end
                    default: r_bit_cnt <= r_bit_cnt;
                endcase
            end
        end
    end

    // SDA is released combinationally while reset is asserted.
    assign sda_oe   = w_sda_oe & rst_n;
    assign busy     = w_busy;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_first = r_rx_first;
    assign overrun  = r_overrun;

endmodule
